// File: rtl/mips_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS memory responder slice: the controller
// state type and the default width constants used by the top and the RAM.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  // Controller modes: waiting for a host, streaming a program in, CPU running
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } memstate_t;

  localparam int DEF_AWIDTH   = 5;
  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_TEXT_TOP = 16;

endpackage

// File: rtl/mips_mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port synchronous byte RAM with a registered read port. A read and a
// write to the same address in one cycle return the old contents.
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high, clears the read register only
//   clr_i    synchronous clear of the read register (memory untouched)
//   re_i     read enable: rdata_o <= mem[addr_i] at the edge
//   we_i     write enable: mem[addr_i] <= wdata_i at the edge
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data, holds between reads
// ---------------------------------------------------------------------------
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Storage array is deliberately never reset so a program survives reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Read register samples the pre-write contents, giving read-before-write
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_mem_responder
// Program memory for a small MIPS core. A host streams a program into the
// RAM while the core is held in reset; the core is then released and uses
// the same RAM with a one-cycle read latency.
// Optional feature: define TEXT_WP_EN to write-protect CPU stores below
// TEXT_TOP and report them on the sticky wp_err flag.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   adr                  CPU byte address, low AWIDTH bits decoded
//   writedata            CPU store data
//   memread, memwrite    CPU strobes, honoured only while running
//   memdata              CPU read data, 0 unless running
//   ld_start             host request to (re)start a load
//   ld_valid/ld_data/ld_last  host load stream
//   ld_ready             high while loading
//   cpu_reset            holds the core in reset unless running
//   wp_err               sticky write-protect violation (0 without TEXT_WP_EN)
// ---------------------------------------------------------------------------
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int TEXT_TOP = DEF_TEXT_TOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] adr,
  input  logic [DWIDTH-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DWIDTH-1:0] memdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic              wp_err
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  // Elaboration-time sanity checks on the parameter set
  if (AWIDTH > DWIDTH) begin : g_badAwidth
    $error("AWIDTH must not exceed DWIDTH");
  end
  if (TEXT_TOP < 0 || TEXT_TOP > DEPTH) begin : g_badTextTop
    $error("TEXT_TOP must lie within the memory");
  end

  memstate_t         state_q, state_d;
  logic [AWIDTH-1:0] ldCnt_q, ldCnt_d;
  logic [AWIDTH-1:0] cpuAddr;
  logic              ldAccept;
  logic              ldDone;
  logic              wpBlock;

  logic              ramWe;
  logic              ramRe;
  logic              ramClr;
  logic [AWIDTH-1:0] ramAddr;
  logic [DWIDTH-1:0] ramWdata;
  logic [DWIDTH-1:0] ramRdata;

  assign cpuAddr = adr[AWIDTH-1:0];

  // Upper address bits alias onto the decoded range
  if (DWIDTH > AWIDTH) begin : g_adrHi
    logic unusedAdrHi;
    assign unusedAdrHi = ^adr[DWIDTH-1:AWIDTH];
  end

  // A load byte is taken whenever the host offers one during LOAD; the load
  // finishes on the marked last byte or when the final address is filled
  assign ldAccept = (state_q == LOAD) && ld_valid;
  assign ldDone   = ldAccept && (ld_last || (ldCnt_q == LAST_ADDR));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ld_start is only honoured outside LOAD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_start) state_d = LOAD;
      LOAD:    if (ldDone)   state_d = RUN;
      RUN:     if (ld_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Load pointer: cleared when a load begins, advanced per accepted byte,
  // and held on the final byte so it never wraps within a load
  always_comb begin
    ldCnt_d = ldCnt_q;
    if ((state_q != LOAD) && ld_start) begin
      ldCnt_d = '0;
    end else if (ldAccept && !ldDone) begin
      ldCnt_d = ldCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ldCnt_q <= '0;
    end else begin
      ldCnt_q <= ldCnt_d;
    end
  end

`ifdef TEXT_WP_EN
  logic wpErr_q;

  assign wpBlock = int'(cpuAddr) < TEXT_TOP;

  // Any CPU store into the text region is dropped and latched as an error
  always_ff @(posedge clk) begin
    if (reset) begin
      wpErr_q <= 1'b0;
    end else if ((state_q == RUN) && memwrite && wpBlock) begin
      wpErr_q <= 1'b1;
    end
  end

  assign wp_err = wpErr_q;
`else
  assign wpBlock = 1'b0;
  assign wp_err  = 1'b0;
`endif

  // Output logic: handshake/reset outputs and RAM port ownership by state.
  // The loader owns the RAM during LOAD, the CPU during RUN; reset blocks
  // any write in the cycle it is asserted.
  always_comb begin
    cpu_reset = (state_q != RUN);
    ld_ready  = (state_q == LOAD);
    ramWe     = 1'b0;
    ramRe     = 1'b0;
    ramAddr   = cpuAddr;
    ramWdata  = writedata;
    case (state_q)
      LOAD: begin
        ramWe    = ld_valid;
        ramAddr  = ldCnt_q;
        ramWdata = ld_data;
      end
      RUN: begin
        ramWe = memwrite && !wpBlock;
        ramRe = memread;
      end
      default: ;
    endcase
    if (reset) begin
      ramWe = 1'b0;
    end
  end

  // Read register is kept clear outside RUN so the CPU always starts from 0
  assign ramClr  = (state_q != RUN);
  assign memdata = (state_q == RUN) ? ramRdata : '0;

  mem_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_memArray (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ramClr),
    .re_i   (ramRe),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

endmodule

// File: tb/tb_mips_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_responder
// Directed self-checking bench for mips_mem_responder with default
// parameters (32-byte memory, 8-bit data, TEXT_TOP = 16). Expectations for
// protected stores follow the TEXT_WP_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_mips_mem_responder;

`ifdef TEXT_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] adr = '0;
  logic [7:0] writedata = '0;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] memdata;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       cpu_reset;
  logic       wp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .adr      (adr),
    .writedata(writedata),
    .memread  (memread),
    .memwrite (memwrite),
    .memdata  (memdata),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_reset(cpu_reset),
    .wp_err   (wp_err)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic startLoad;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic loadByte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpuRead(input logic [7:0] a);
    adr     = a;
    memread = 1'b1;
    tick();
    memread = 1'b0;
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  // Reset state of every output
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_cpu_reset got %b want 1", cpu_reset);
    end
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ld_ready got %b want 0", ld_ready);
    end
    checks++;
    if (memdata !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_memdata got %h want 00", memdata);
    end
    checks++;
    if (wp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wp_err got %b want 0", wp_err);
    end
    // CPU strobes in IDLE must not produce data
    cpuRead(8'h00);
    checks++;
    if (memdata !== 8'h00) begin
      errors++; $display("[TB] FAIL idle_memdata got %h want 00", memdata);
    end
  endtask

  // Three-byte load followed by a read with one-cycle latency
  task automatic test_load_basic;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    startLoad();
    checks++;
    if (cpu_reset !== 1'b1 || memdata !== 8'h00) begin
      errors++; $display("[TB] FAIL load_entry got cpu_reset=%b memdata=%h want 1/00", cpu_reset, memdata);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL load_ready_%0d got %b want 1", i, ld_ready);
      end
      loadByte(bytes[i], i == 2);
    end
    checks++;
    if (cpu_reset !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL load_to_run got cpu_reset=%b ld_ready=%b want 0/0", cpu_reset, ld_ready);
    end
    cpuRead(8'h02);
    checks++;
    if (memdata !== 8'h33) begin
      errors++; $display("[TB] FAIL basic_read2 got %h want 33", memdata);
    end
    tick();
    checks++;
    if (memdata !== 8'h33) begin
      errors++; $display("[TB] FAIL basic_hold got %h want 33", memdata);
    end
    cpuRead(8'h00);
    checks++;
    if (memdata !== 8'h11) begin
      errors++; $display("[TB] FAIL basic_read0 got %h want 11", memdata);
    end
  endtask

  // Fill all 32 bytes without ld_last; RUN must follow byte 31
  task automatic test_full_load;
    startLoad();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        checks++;
        if (cpu_reset !== 1'b1 || ld_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL full_before_last got cpu_reset=%b ld_ready=%b want 1/1", cpu_reset, ld_ready);
        end
      end
      loadByte(8'h40 + 8'(i), 1'b0);
    end
    checks++;
    if (cpu_reset !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_to_run got cpu_reset=%b ld_ready=%b want 0/0", cpu_reset, ld_ready);
    end
    cpuRead(8'h21);
    checks++;
    if (memdata !== 8'h41) begin
      errors++; $display("[TB] FAIL alias_read got %h want 41", memdata);
    end
    cpuRead(8'h1F);
    checks++;
    if (memdata !== 8'h5F) begin
      errors++; $display("[TB] FAIL full_last_byte got %h want 5F", memdata);
    end
  endtask

  // Simultaneous read and write returns the old contents
  task automatic test_read_write_same;
    cpuWrite(8'h05, 8'h5A);
    adr       = 8'h05;
    writedata = 8'hA5;
    memread   = 1'b1;
    memwrite  = 1'b1;
    tick();
    memread   = 1'b0;
    memwrite  = 1'b0;
    checks++;
    if (memdata !== (WP ? 8'h45 : 8'h5A)) begin
      errors++; $display("[TB] FAIL rbw_old got %h want %h", memdata, WP ? 8'h45 : 8'h5A);
    end
    cpuRead(8'h05);
    checks++;
    if (memdata !== (WP ? 8'h45 : 8'hA5)) begin
      errors++; $display("[TB] FAIL rbw_new got %h want %h", memdata, WP ? 8'h45 : 8'hA5);
    end
    checks++;
    if (wp_err !== WP) begin
      errors++; $display("[TB] FAIL rbw_wp_err got %b want %b", wp_err, WP);
    end
  endtask

  // Reset two bytes into a four-byte load, then reload a single byte
  task automatic test_reset_mid_load;
    startLoad();
    loadByte(8'hA0, 1'b0);
    loadByte(8'hA1, 1'b0);
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hA2;
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    checks++;
    if (ld_ready !== 1'b0 || cpu_reset !== 1'b1 || memdata !== 8'h00) begin
      errors++; $display("[TB] FAIL midload_reset got ld_ready=%b cpu_reset=%b memdata=%h want 0/1/00", ld_ready, cpu_reset, memdata);
    end
    startLoad();
    loadByte(8'h77, 1'b1);
    cpuRead(8'h01);
    checks++;
    if (memdata !== 8'hA1) begin
      errors++; $display("[TB] FAIL midload_kept got %h want A1", memdata);
    end
    cpuRead(8'h02);
    checks++;
    if (memdata !== 8'h42) begin
      errors++; $display("[TB] FAIL midload_reset_dominates got %h want 42", memdata);
    end
    cpuRead(8'h00);
    checks++;
    if (memdata !== 8'h77) begin
      errors++; $display("[TB] FAIL midload_reload got %h want 77", memdata);
    end
  endtask

  // Gaps in ld_valid, plus an ignored ld_start mid-load
  task automatic test_valid_gaps;
    startLoad();
    checks++;
    if (memdata !== 8'h00 || cpu_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL reload_entry got memdata=%h cpu_reset=%b want 00/1", memdata, cpu_reset);
    end
    for (int i = 0; i < 4; i++) begin
      loadByte(8'hC0 + 8'(i), i == 3);
      if (i < 3) begin
        ld_data = 8'hEE;
        for (int g = 0; g < 3; g++) begin
          ld_start = (i == 1) && (g == 0);
          tick();
        end
        ld_start = 1'b0;
        checks++;
        if (ld_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL gap_ready_%0d got %b want 1", i, ld_ready);
        end
      end
    end
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++; $display("[TB] FAIL gap_to_run got %b want 0", cpu_reset);
    end
    for (int i = 0; i < 4; i++) begin
      cpuRead(8'(i));
      checks++;
      if (memdata !== 8'hC0 + 8'(i)) begin
        errors++; $display("[TB] FAIL gap_byte_%0d got %h want %h", i, memdata, 8'hC0 + 8'(i));
      end
    end
    cpuRead(8'h04);
    checks++;
    if (memdata !== 8'h44) begin
      errors++; $display("[TB] FAIL gap_no_spurious got %h want 44", memdata);
    end
  endtask

  // Text-region protection (or its absence) and wp_err stickiness
  task automatic test_write_protect;
    pulseReset();
    checks++;
    if (wp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wp_after_reset got %b want 0", wp_err);
    end
    startLoad();
    loadByte(8'h99, 1'b1);
    cpuWrite(8'h03, 8'hFF);
    checks++;
    if (wp_err !== WP) begin
      errors++; $display("[TB] FAIL wp_flag got %b want %b", wp_err, WP);
    end
    cpuRead(8'h03);
    checks++;
    if (memdata !== (WP ? 8'hC3 : 8'hFF)) begin
      errors++; $display("[TB] FAIL wp_low_write got %h want %h", memdata, WP ? 8'hC3 : 8'hFF);
    end
    cpuWrite(8'h10, 8'h66);
    cpuRead(8'h10);
    checks++;
    if (memdata !== 8'h66) begin
      errors++; $display("[TB] FAIL wp_top_write got %h want 66", memdata);
    end
    tick();
    tick();
    checks++;
    if (wp_err !== WP) begin
      errors++; $display("[TB] FAIL wp_sticky got %b want %b", wp_err, WP);
    end
    cpuRead(8'h00);
    checks++;
    if (memdata !== 8'h99) begin
      errors++; $display("[TB] FAIL wp_loader_unprotected got %h want 99", memdata);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_full_load();
    test_read_write_same();
    test_reset_mid_load();
    test_valid_gaps();
    test_write_protect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
